// File: rtl/timer_mmss.sv
// timer_mmss: BCD mm:ss stopwatch counting synchronised 1 Hz ticks under debounced start/stop and clear keys
module timer_mmss #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W = 18
) (
  input  logic       MCLK,
  input  logic       RST_N,
  input  logic       CLK_SEC,
  input  logic       KEY_SS_N,
  input  logic       KEY_CLR_N,
  output logic [3:0] MIN_T,
  output logic [3:0] MIN_U,
  output logic [3:0] SEC_T,
  output logic [3:0] SEC_U,
  output logic       RUNNING,
  output logic       WRAP
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state;
  logic [2:0] sec_sh;
  logic tick;
  logic [1:0] keys, fall, press;
  logic [2:0] key_sh [2];
  logic [DB_W-1:0] lock [2];
  logic su_w, st_w, mu_w, mt_w;
  assign keys = {KEY_CLR_N, KEY_SS_N};
  assign su_w = SEC_U == 4'd9;
  assign st_w = su_w && SEC_T == 4'd5;
  assign mu_w = st_w && MIN_U == 4'd9;
  assign mt_w = mu_w && MIN_T == 4'd5;
  // a press is a synchronised falling edge seen while that key is not locked out
  always_comb
    for (int i = 0; i < 2; i++) fall[i] = ~key_sh[i][1] & key_sh[i][2] & (lock[i] == '0);
  // CLK_SEC synchroniser (sh[1:0]) and previous-value flop (sh[2]); tick is registered
  always_ff @(posedge MCLK or negedge RST_N)
    if (!RST_N) begin
      sec_sh <= '0;
      tick <= 1'b0;
    end else begin
      sec_sh <= {sec_sh[1:0], CLK_SEC};
      tick <= sec_sh[1] & ~sec_sh[2];
    end
  // key synchronisers, registered press pulses and lockout counters
  always_ff @(posedge MCLK or negedge RST_N)
    if (!RST_N) begin
      for (int i = 0; i < 2; i++) begin
        key_sh[i] <= '1;
        lock[i] <= '0;
      end
      press <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        key_sh[i] <= {key_sh[i][1:0], keys[i]};
        lock[i] <= fall[i] ? DB_W'(DEBOUNCE_CYCLES) : lock[i] - DB_W'(lock[i] != '0);
      end
      press <= fall;
    end
  // control FSM with BCD cascade; clear wins over start/stop and tick
  always_ff @(posedge MCLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      {MIN_T, MIN_U, SEC_T, SEC_U} <= '0;
      RUNNING <= 1'b0;
      WRAP <= 1'b0;
    end else begin
      WRAP <= 1'b0;
      if (press[1]) begin
        state <= IDLE;
        {MIN_T, MIN_U, SEC_T, SEC_U} <= '0;
        RUNNING <= 1'b0;
      end else begin
        if (tick && state == RUN) begin
          SEC_U <= su_w ? 4'd0 : SEC_U + 4'd1;
          SEC_T <= st_w ? 4'd0 : su_w ? SEC_T + 4'd1 : SEC_T;
          MIN_U <= mu_w ? 4'd0 : st_w ? MIN_U + 4'd1 : MIN_U;
          MIN_T <= mt_w ? 4'd0 : mu_w ? MIN_T + 4'd1 : MIN_T;
          WRAP <= mt_w;
        end
        if (press[0]) begin
          state <= state == RUN ? PAUSE : RUN;
          RUNNING <= state != RUN;
        end
      end
    end
endmodule

// File: tb/tb_timer_mmss.sv
// tb_timer_mmss: scoreboard bench for the mm:ss stopwatch; every output change is matched against a queued expectation and cycle
module tb_timer_mmss;
  logic MCLK = 0, RST_N = 0, CLK_SEC = 0, KEY_SS_N = 1, KEY_CLR_N = 1;
  logic [3:0] MIN_T, MIN_U, SEC_T, SEC_U;
  logic RUNNING, WRAP;
  logic [17:0] obs, prev_obs = '0, cur_exp = '0;
  typedef struct {logic [17:0] v; int c;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0, secs = 0, st = 0;

  timer_mmss #(.DEBOUNCE_CYCLES(4), .DB_W(3)) dut (
    .MCLK(MCLK), .RST_N(RST_N), .CLK_SEC(CLK_SEC), .KEY_SS_N(KEY_SS_N), .KEY_CLR_N(KEY_CLR_N),
    .MIN_T(MIN_T), .MIN_U(MIN_U), .SEC_T(SEC_T), .SEC_U(SEC_U), .RUNNING(RUNNING), .WRAP(WRAP)
  );

  always #5 MCLK = ~MCLK;
  always @(posedge MCLK) cyc++;
  assign obs = {MIN_T, MIN_U, SEC_T, SEC_U, RUNNING, WRAP};

  function automatic void check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, e, cyc);
    end
  endfunction

  // st: 0 idle, 1 run, 2 pause
  function automatic logic [17:0] model_vec(input bit w);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), st == 1, w};
  endfunction

  function automatic void push(input logic [17:0] v, input int c);
    if (v != cur_exp) begin
      q.push_back('{v, c});
      cur_exp = v;
    end
  endfunction

  // monitor: any change of the outputs pops one expectation; overdue expectations are timeouts
  always @(negedge MCLK) begin : mon
    exp_t e;
    if (obs !== prev_obs) begin
      if (q.size() == 0) check("unexpected_change", 32'(obs), 32'(prev_obs));
      else begin
        e = q.pop_front();
        check("value", 32'(obs), 32'(e.v));
        check("latency", cyc, e.c);
      end
      prev_obs = obs;
    end else if (q.size() > 0 && cyc > q[0].c) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0h expected %0h by cycle %0d", obs, q[0].v, q[0].c);
      void'(q.pop_front());
    end
  end

  // drive any mix of ss press, clr press and CLK_SEC rise in one cycle; called at a negedge
  task automatic ev(input bit ss, input bit clr, input bit tk);
    int c;
    bit w;
    c = cyc;
    w = 0;
    if (ss) KEY_SS_N = 0;
    if (clr) KEY_CLR_N = 0;
    if (tk) CLK_SEC = 1;
    if (clr) begin
      st = 0;
      secs = 0;
    end else begin
      if (tk && st == 1) begin
        secs = (secs + 1) % 3600;
        w = secs == 0;
      end
      if (ss) st = st == 1 ? 2 : 1;
    end
    push(model_vec(w), c + 4);
    if (w) push(model_vec(0), c + 5);
    repeat (2) @(negedge MCLK);
    KEY_SS_N = 1;
    KEY_CLR_N = 1;
    CLK_SEC = 0;
    repeat ((ss || clr) ? 8 : 3) @(negedge MCLK);
  endtask

  // low/high/low bounce on ss: only the first fall is accepted
  task automatic bounce_ss();
    int c;
    c = cyc;
    KEY_SS_N = 0;
    @(negedge MCLK) KEY_SS_N = 1;
    @(negedge MCLK) KEY_SS_N = 0;
    st = st == 1 ? 2 : 1;
    push(model_vec(0), c + 4);
    repeat (2) @(negedge MCLK);
    KEY_SS_N = 1;
    repeat (10) @(negedge MCLK);
  endtask

  initial begin
    repeat (2) @(negedge MCLK);
    check("reset_outputs", 32'(obs), 0);
    RST_N = 1;
    repeat (2) @(negedge MCLK);
    repeat (2) ev(0, 0, 1);
    check("idle_ignores_ticks", 32'(obs), 0);
    ev(1, 0, 0);
    repeat (3) ev(0, 0, 1);
    check("time_0003", 32'(obs), 32'({16'h0003, 2'b10}));
    ev(0, 1, 0);
    bounce_ss();
    repeat (2) ev(0, 0, 1);
    ev(1, 0, 0);
    repeat (2) ev(0, 0, 1);
    check("pause_holds", 32'(obs), 32'({16'h0002, 2'b00}));
    ev(1, 0, 0);
    ev(0, 0, 1);
    check("resume_0003", 32'(obs), 32'({16'h0003, 2'b10}));
    ev(0, 1, 0);
    ev(1, 0, 0);
    repeat (600) ev(0, 0, 1);
    check("time_1000", 32'(obs), 32'({16'h1000, 2'b10}));
    ev(0, 1, 0);
    ev(1, 0, 0);
    repeat (3599) ev(0, 0, 1);
    check("time_5959", 32'(obs), 32'({16'h5959, 2'b10}));
    ev(0, 0, 1);
    check("after_wrap", 32'(obs), 32'({16'h0000, 2'b10}));
    ev(0, 0, 1);
    ev(1, 1, 1);
    check("clr_ss_tick", 32'(obs), 0);
    ev(1, 0, 0);
    repeat (2) ev(0, 0, 1);
    ev(1, 0, 1);
    check("ss_tick_run", 32'(obs), 32'({16'h0003, 2'b00}));
    ev(1, 0, 0);
    ev(0, 0, 1);
    #2 RST_N = 0;
    st = 0;
    secs = 0;
    push(model_vec(0), cyc + 1);
    #1 check("async_reset", 32'(obs), 0);
    repeat (2) @(negedge MCLK);
    RST_N = 1;
    repeat (2) @(negedge MCLK);
    ev(1, 0, 0);
    ev(0, 0, 1);
    check("after_reset_run", 32'(obs), 32'({16'h0001, 2'b10}));
    repeat (5) @(negedge MCLK);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
